// File: rtl/dm_arbiter.sv
// Two-port arbiter and one-cycle access sequencer for the single-port data memory.
// Build option: define DM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module dm_arbiter #(
    parameter int         ADDR_W    = 32,
    parameter logic [2:0] WORD_TYPE = 3'b000,
    parameter logic [2:0] HALF_TYPE = 3'b001,
    parameter logic [2:0] BYTE_TYPE = 3'b010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic              we0,
    input  logic              we1,
    input  logic [2:0]        type0,
    input  logic [2:0]        type1,
    input  logic [31:0]       pc0,
    input  logic [31:0]       pc1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] dm_a,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    output logic [2:0]        dm_type,
    output logic [31:0]       dm_pc,
    input  logic [31:0]       dm_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;
    logic        err_reg, err_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        grant;

    logic [1:0]        req_vec, we_vec, fault_vec, ack_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [31:0]       wdata_vec [2];
    logic [31:0]       pc_vec    [2];
    logic [2:0]        type_vec  [2];

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;
    assign pc_vec[0]    = pc0;
    assign pc_vec[1]    = pc1;
    assign type_vec[0]  = type0;
    assign type_vec[1]  = type1;

    function automatic logic is_fault(input logic [1:0] lo, input logic [2:0] typ);
        logic f;
        f = 1'b0;
        if (typ > BYTE_TYPE)
            f = 1'b1;
        else if (typ == WORD_TYPE && lo != 2'b00)
            f = 1'b1;
        else if (typ == HALF_TYPE && lo[0])
            f = 1'b1;
        return f;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign fault_vec[gi] = is_fault(addr_vec[gi][1:0], type_vec[gi]);
            // Response flags come straight from state so a reset in RESP drops them at once.
            assign ack_vec[gi]   = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign ack0  = ack_vec[0];
    assign ack1  = ack_vec[1];
    assign err0  = ack_vec[0] & err_reg;
    assign err1  = ack_vec[1] & err_reg;
    assign rdata = rdata_reg;

`ifdef DM_ARB_RR_EN
    logic last_owner_reg, last_owner_next;
    assign grant = (req0 && req1) ? ~last_owner_reg : ~req0;
`else
    assign grant = ~req0;
`endif

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        err_next   = err_reg;
        rdata_next = rdata_reg;
`ifdef DM_ARB_RR_EN
        last_owner_next = last_owner_reg;
`endif
        dm_a     = '0;
        dm_wdata = '0;
        dm_we    = 1'b0;
        dm_type  = WORD_TYPE;
        dm_pc    = '0;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    owner_next = grant;
`ifdef DM_ARB_RR_EN
                    last_owner_next = grant;
`endif
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                dm_a       = addr_vec[owner_reg];
                dm_wdata   = wdata_vec[owner_reg];
                dm_type    = type_vec[owner_reg];
                dm_pc      = pc_vec[owner_reg];
                dm_we      = we_vec[owner_reg] & ~fault_vec[owner_reg];
                err_next   = fault_vec[owner_reg];
                rdata_next = (!we_vec[owner_reg] && !fault_vec[owner_reg]) ? dm_rd : 32'h0;
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= 32'h0;
`ifdef DM_ARB_RR_EN
            last_owner_reg <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
`ifdef DM_ARB_RR_EN
            last_owner_reg <= last_owner_next;
`endif
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a byte-addressed data-memory model on the DM side.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
    logic [2:0]  type0, type1;
    logic        ack0, ack1, err0, err1, dm_we;
    logic [31:0] rdata, dm_a, dm_wdata, dm_pc, dm_rd;
    logic [2:0]  dm_type;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .type0(type0), .type1(type1),
        .pc0(pc0), .pc1(pc1),
        .ack0(ack0), .ack1(ack1),
        .err0(err0), .err1(err1),
        .rdata(rdata),
        .dm_a(dm_a), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .dm_type(dm_type), .dm_pc(dm_pc), .dm_rd(dm_rd)
    );

    // Little-endian data memory: combinational sign-extending read, store on posedge.
    logic [7:0] mem [256];
    logic [7:0] ma;
    assign ma = dm_a[7:0];

    always_comb begin
        dm_rd = 32'h0;
        case (dm_type)
            3'b000: dm_rd = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
            3'b001: dm_rd = {{16{mem[ma + 8'd1][7]}}, mem[ma + 8'd1], mem[ma]};
            3'b010: dm_rd = {{24{mem[ma][7]}}, mem[ma]};
            default: dm_rd = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (dm_we) begin
            case (dm_type)
                3'b000: begin
                    mem[ma]         <= dm_wdata[7:0];
                    mem[ma + 8'd1]  <= dm_wdata[15:8];
                    mem[ma + 8'd2]  <= dm_wdata[23:16];
                    mem[ma + 8'd3]  <= dm_wdata[31:24];
                end
                3'b001: begin
                    mem[ma]         <= dm_wdata[7:0];
                    mem[ma + 8'd1]  <= dm_wdata[15:8];
                end
                3'b010: mem[ma] <= dm_wdata[7:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_writes;
    } vec_t;

    vec_t vecs [13];

    task automatic drive_port(input logic port, input logic r, input logic w, input logic [2:0] t,
                              input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        if (port) begin
            req1 = r; we1 = w; type1 = t; addr1 = a; wdata1 = d; pc1 = p;
        end else begin
            req0 = r; we0 = w; type0 = t; addr0 = a; wdata0 = d; pc0 = p;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        int   writes;
        logic got;
        lat = 0; writes = 0; got = 1'b0;
        @(negedge clk);
        drive_port(v.port, 1'b1, v.we, v.typ, v.addr, v.wdata, v.pc);
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (dm_we) writes++;
            if (c == 1) begin
                chk("dm_a_in_access", dm_a, v.addr);
                chk("dm_pc_in_access", dm_pc, v.pc);
            end
            if (ack0 || ack1) begin
                got = 1'b1;
                lat = c;
                chk("ack_own", 32'(v.port ? ack1 : ack0), 32'd1);
                chk("ack_other", 32'(v.port ? ack0 : ack1), 32'd0);
                chk("err", 32'(v.port ? err1 : err0), 32'(v.exp_err));
                chk("rdata", rdata, v.exp_rdata);
                $display("txn port=%0d we=%0d type=%0d addr=%h wdata=%h -> err=%0d rdata=%h",
                         v.port, v.we, v.typ, v.addr, v.wdata, v.port ? err1 : err0, rdata);
            end
        end
        chk("ack_latency", 32'(lat), 32'd2);
        chk("dm_write_count", 32'(writes), 32'(v.exp_writes));
        drive_port(v.port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    endtask

    int          grants [4];
    int          ng;
    logic        rr0, rr1;
    int          k, last, writes;
    logic        got;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];
    logic [31:0] mword;

    initial begin
        reset = 1'b1; clr = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; type0 = 0; type1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; pc0 = 0; pc1 = 0;

        //          port we   type    addr      wdata         pc        err  rdata        writes
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h3000, 1'b0, 32'h0,        1};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h10, 32'h0,        32'h5000, 1'b0, 32'hDEADBEEF, 0};
        vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h13, 32'h0000CAFE, 32'h3004, 1'b1, 32'h0,        0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h10, 32'h0,        32'h5004, 1'b0, 32'hDEADBEEF, 0};
        vecs[4]  = '{1'b0, 1'b0, 3'b101, 32'h10, 32'h0,        32'h3008, 1'b1, 32'h0,        0};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h13, 32'h000000AB, 32'h300C, 1'b0, 32'h0,        1};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h13, 32'h0,        32'h5008, 1'b0, 32'hFFFFFFAB, 0};
        vecs[7]  = '{1'b0, 1'b0, 3'b000, 32'h10, 32'h0,        32'h3010, 1'b0, 32'hABADBEEF, 0};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'h500C, 1'b0, 32'hFFFFABAD, 0};
        vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h11, 32'h11111111, 32'h3014, 1'b1, 32'h0,        0};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h5010, 1'b0, 32'hFFFFFFEF, 0};
        vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h14, 32'h00001234, 32'h3018, 1'b0, 32'h0,        1};
        vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h14, 32'h0,        32'h5014, 1'b0, 32'h00001234, 0};

        b2b_addr[0] = 32'h10; b2b_exp[0] = 32'hABADBEEF;
        b2b_addr[1] = 32'h14; b2b_exp[1] = 32'h00001234;
        b2b_addr[2] = 32'h20; b2b_exp[2] = 32'h12345678;
        b2b_addr[3] = 32'h00; b2b_exp[3] = 32'h00000000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_dm_a", dm_a, 32'h0);
        chk("rst_dm_type", 32'(dm_type), 32'd0);
        reset = 1'b0; clr = 1'b0;

        // Single accesses from the vector table
        foreach (vecs[i]) run_vec(vecs[i]);

        // Contention: each requester re-raises in the IDLE cycle after its ack
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        drive_port(1'b1, 1'b1, 1'b0, 3'b000, 32'h14, 32'h0, 32'h0);
        ng = 0; rr0 = 0; rr1 = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (ack0 && ack1) chk("dual_ack", 32'd1, 32'd0);
            if (rr0) begin req0 = 1'b1; rr0 = 1'b0; end
            if (rr1) begin req1 = 1'b1; rr1 = 1'b0; end
            if (ack0 && !ack1) begin grants[ng] = 0; ng++; req0 = 1'b0; rr0 = 1'b1; $display("txn contention grant=0"); end
            if (ack1 && !ack0) begin grants[ng] = 1; ng++; req1 = 1'b0; rr1 = 1'b1; $display("txn contention grant=1"); end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("contention_grants", 32'(ng), 32'd4);
`ifdef DM_ARB_RR_EN
        chk("rr_grant0", 32'(grants[0]), 32'd0);
        chk("rr_grant1", 32'(grants[1]), 32'd1);
        chk("rr_grant2", 32'(grants[2]), 32'd0);
        chk("rr_grant3", 32'(grants[3]), 32'd1);
`else
        chk("fp_grant0", 32'(grants[0]), 32'd0);
        chk("fp_grant1", 32'(grants[1]), 32'd0);
        chk("fp_grant2", 32'(grants[2]), 32'd0);
        chk("fp_grant3", 32'(grants[3]), 32'd0);
`endif
        repeat (2) @(negedge clk);

        // Reset during ACCESS of a port 1 store
        drive_port(1'b1, 1'b1, 1'b1, 3'b000, 32'h20, 32'h12345678, 32'h6000);
        @(negedge clk);
        chk("pre_reset_dm_we", 32'(dm_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset_dm_we", 32'(dm_we), 32'd0);
        chk("midreset_dm_a", dm_a, 32'h0);
        chk("midreset_ack1", 32'(ack1), 32'd0);
        chk("midreset_err1", 32'(err1), 32'd0);
        chk("midreset_rdata", rdata, 32'h0);
        @(negedge clk);
        chk("midreset_ack1_held", 32'(ack1), 32'd0);
        mword = {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]};
        chk("no_write_during_reset", mword, 32'h0);
        reset = 1'b0;
        got = 1'b0; writes = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (dm_we) writes++;
            if (ack1) begin
                got = 1'b1;
                chk("resumed_latency", 32'(c), 32'd2);
                chk("resumed_err1", 32'(err1), 32'd0);
                $display("txn resumed port=1 store addr=00000020 err=%0d", err1);
            end
        end
        chk("resumed_ack1_seen", 32'(got), 32'd1);
        chk("resumed_writes", 32'(writes), 32'd1);
        drive_port(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        run_vec('{1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'h3020, 1'b0, 32'h12345678, 0});

        // Back-to-back loads with req0 held high
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 3'b000, b2b_addr[0], 32'h0, 32'h3100);
        k = 0; last = 0; writes = 0;
        for (int c = 1; c <= 30 && k < 4; c++) begin
            @(negedge clk);
            if (dm_we) writes++;
            if (ack0) begin
                chk("b2b_rdata", rdata, b2b_exp[k]);
                chk("b2b_interval", 32'(c - last), (k == 0) ? 32'd2 : 32'd3);
                $display("txn b2b load %0d addr=%h rdata=%h", k, addr0, rdata);
                last = c;
                k++;
                if (k < 4) addr0 = b2b_addr[k];
            end
        end
        req0 = 1'b0;
        chk("b2b_count", 32'(k), 32'd4);
        chk("b2b_no_write", 32'(writes), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
